// File: rtl/usb_mux_pkg.sv
// Shared types and constants for the FT245 upstream TX arbiter.
package usb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef logic ch_t;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hC0;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker; favours the channel that did not go last.
module rr_pick2
  import usb_mux_pkg::*;
(
  input  logic [1:0] req_i,
  input  ch_t        last_ch_i,
  input  logic       last_valid_i,
  output ch_t        pick_o,
  output logic       any_o
);

  always_comb begin
    any_o  = |req_i;
    pick_o = 1'b0;
    case (req_i)
      2'b01:   pick_o = 1'b0;
      2'b10:   pick_o = 1'b1;
      2'b11:   pick_o = last_valid_i ? ~last_ch_i : 1'b0;
      default: pick_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Burst arbiter sharing the FT245 upstream byte path between two show-ahead TX FIFOs,
// inserting a channel header byte whenever the granted channel changes.
module usb_tx_arbiter
  import usb_mux_pkg::*;
#(
  parameter int         MAX_BURST = 64,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_ASYNC,
  input  logic       CH0_EMPTY,
  input  logic [7:0] CH0_Q,
  output logic       CH0_RDREQ,
  input  logic       CH1_EMPTY,
  input  logic [7:0] CH1_Q,
  output logic       CH1_RDREQ,
  output logic       OUT_EMPTY,
  output logic [7:0] OUT_Q,
  input  logic       OUT_RDREQ,
  output logic       GRANT_VALID,
  output logic       GRANT_CH
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

  state_t        state_q;
  ch_t           grant_ch_q;
  ch_t           last_ch_q;
  logic          last_valid_q;
  logic [CW-1:0] burst_cnt_q;
  logic [CW-1:0] burst_cnt_d;

  ch_t           pick;
  logic          any;
  logic          sel_empty;
  logic [7:0]    sel_q;
  logic          pop;

  rr_pick2 u_pick (
    .req_i       ({~CH1_EMPTY, ~CH0_EMPTY}),
    .last_ch_i   (last_ch_q),
    .last_valid_i(last_valid_q),
    .pick_o      (pick),
    .any_o       (any)
  );

  // Output port looks like a show-ahead FIFO: purely combinational from state and the granted FIFO.
  always_comb begin
    sel_empty   = grant_ch_q ? CH1_EMPTY : CH0_EMPTY;
    sel_q       = grant_ch_q ? CH1_Q : CH0_Q;
    pop         = (state_q == DATA) && OUT_RDREQ && !sel_empty;
    burst_cnt_d = burst_cnt_q + CW'(1);
    CH0_RDREQ   = pop && !grant_ch_q;
    CH1_RDREQ   = pop && grant_ch_q;
    GRANT_VALID = (state_q != IDLE);
    GRANT_CH    = grant_ch_q;
    OUT_EMPTY   = 1'b1;
    OUT_Q       = 8'h00;
    case (state_q)
      HDR: begin
        OUT_EMPTY = 1'b0;
        OUT_Q     = HDR_BASE | {7'd0, grant_ch_q};
      end
      DATA: begin
        OUT_EMPTY = sel_empty;
        OUT_Q     = sel_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state_q      <= IDLE;
      grant_ch_q   <= 1'b0;
      last_ch_q    <= 1'b0;
      last_valid_q <= 1'b0;
      burst_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            grant_ch_q  <= pick;
            burst_cnt_q <= '0;
            state_q     <= (!last_valid_q || (pick != last_ch_q)) ? HDR : DATA;
          end
        end
        HDR: begin
          if (OUT_RDREQ) begin
            last_ch_q    <= grant_ch_q;
            last_valid_q <= 1'b1;
            state_q      <= DATA;
          end
        end
        DATA: begin
          // An empty FIFO ends the burst early so the other channel can be served.
          if (pop) begin
            burst_cnt_q <= burst_cnt_d;
            if (burst_cnt_d == BURST_LIMIT) state_q <= IDLE;
          end else if (sel_empty) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: cycle vector table plus multi-cycle stream sequences.
module tb_usb_tx_arbiter;

  logic       CLK;
  logic       RST_ASYNC;
  logic       CH0_EMPTY, CH1_EMPTY;
  logic [7:0] CH0_Q, CH1_Q;
  logic       CH0_RDREQ, CH1_RDREQ;
  logic       OUT_EMPTY;
  logic [7:0] OUT_Q;
  logic       OUT_RDREQ;
  logic       GRANT_VALID, GRANT_CH;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] got[$];
  logic [7:0] expq[$];

  typedef struct packed {
    logic       p0v;
    logic [7:0] p0;
    logic       p1v;
    logic [7:0] p1;
    logic       rd;
    logic       eOe;
    logic [7:0] eQ;
    logic       eR0;
    logic       eR1;
    logic       eGv;
    logic       eGch;
  } vec_t;

  vec_t vt[19];

  usb_tx_arbiter #(.MAX_BURST(64), .HDR_BASE(8'hC0)) dut (
    .CLK        (CLK),
    .RST_ASYNC  (RST_ASYNC),
    .CH0_EMPTY  (CH0_EMPTY),
    .CH0_Q      (CH0_Q),
    .CH0_RDREQ  (CH0_RDREQ),
    .CH1_EMPTY  (CH1_EMPTY),
    .CH1_Q      (CH1_Q),
    .CH1_RDREQ  (CH1_RDREQ),
    .OUT_EMPTY  (OUT_EMPTY),
    .OUT_Q      (OUT_Q),
    .OUT_RDREQ  (OUT_RDREQ),
    .GRANT_VALID(GRANT_VALID),
    .GRANT_CH   (GRANT_CH)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic refreshFifos();
    CH0_EMPTY = (q0.size() == 0);
    CH0_Q     = (q0.size() != 0) ? q0[0] : 8'h00;
    CH1_EMPTY = (q1.size() == 0);
    CH1_Q     = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  // One clock cycle starting at a negedge: sample, record consumed byte, apply pops at the edge.
  task automatic applyStimulus(output logic oe, output logic [7:0] oq, output logic r0,
                               output logic r1, output logic gv, output logic gch);
    logic       legal;
    logic [7:0] tmp;
    refreshFifos();
    #1;
    oe  = OUT_EMPTY;
    oq  = OUT_Q;
    r0  = CH0_RDREQ;
    r1  = CH1_RDREQ;
    gv  = GRANT_VALID;
    gch = GRANT_CH;
    legal = !(r0 && (CH0_EMPTY || !OUT_RDREQ)) && !(r1 && (CH1_EMPTY || !OUT_RDREQ)) && !(r0 && r1);
    if (!legal) checkOutput("pop_legal", {30'd0, r1, r0}, 32'd0);
    if (OUT_RDREQ && !oe) got.push_back(oq);
    @(posedge CLK);
    if (r0 && q0.size() > 0) tmp = q0.pop_front();
    if (r1 && q1.size() > 0) tmp = q1.pop_front();
    @(negedge CLK);
  endtask

  task automatic runStream(input string name, input int budget);
    logic oe, r0, r1, gv, gch;
    logic [7:0] oq;
    int n;
    n = 0;
    gv = 1'b1;
    OUT_RDREQ = 1'b1;
    while (!(q0.size() == 0 && q1.size() == 0 && !gv) && n < budget) begin
      applyStimulus(oe, oq, r0, r1, gv, gch);
      n++;
    end
    checkOutput({name, "_timeout"}, (n < budget) ? 32'd0 : 32'd1, 32'd0);
    checkOutput({name, "_len"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      checkOutput($sformatf("%s[%0d]", name, i), got[i], expq[i]);
  endtask

  task automatic pulseReset();
    logic oe, r0, r1, gv, gch;
    logic [7:0] oq;
    RST_ASYNC = 1'b1;
    OUT_RDREQ = 1'b0;
    applyStimulus(oe, oq, r0, r1, gv, gch);
    RST_ASYNC = 1'b0;
    got.delete();
    expq.delete();
  endtask

  initial begin
    logic oe, r0, r1, gv, gch;
    logic [7:0] oq;
    int n;

    RST_ASYNC = 1'b1;
    OUT_RDREQ = 1'b1;
    refreshFifos();

    vt[0]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    @(negedge CLK);

    // Reset held with both FIFOs loaded: nothing may be offered or popped.
    q0 = '{8'h01, 8'h02};
    q1 = '{8'h03};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(oe, oq, r0, r1, gv, gch);
      checkOutput($sformatf("rst_oe%0d", i), oe, 1'b1);
      checkOutput($sformatf("rst_rd%0d", i), {r1, r0}, 2'b00);
      checkOutput($sformatf("rst_gv%0d", i), gv, 1'b0);
    end
    RST_ASYNC = 1'b0;
    applyStimulus(oe, oq, r0, r1, gv, gch);
    checkOutput("post_rst_oe", oe, 1'b1);
    checkOutput("post_rst_rd", {r1, r0}, 2'b00);
    checkOutput("post_rst_gv", gv, 1'b0);
    expq = '{8'hC0, 8'h01, 8'h02, 8'hC1, 8'h03};
    runStream("rst_drain", 50);

    // Cycle table: single channel, stalls in HDR and DATA, headerless re-grant, channel switch.
    pulseReset();
    for (int i = 0; i < 19; i++) begin
      if (vt[i].p0v) q0.push_back(vt[i].p0);
      if (vt[i].p1v) q1.push_back(vt[i].p1);
      OUT_RDREQ = vt[i].rd;
      applyStimulus(oe, oq, r0, r1, gv, gch);
      checkOutput($sformatf("v%0d_oe", i), oe, vt[i].eOe);
      if (!vt[i].eOe) checkOutput($sformatf("v%0d_q", i), oq, vt[i].eQ);
      checkOutput($sformatf("v%0d_rd0", i), r0, vt[i].eR0);
      checkOutput($sformatf("v%0d_rd1", i), r1, vt[i].eR1);
      checkOutput($sformatf("v%0d_gv", i), gv, vt[i].eGv);
      if (vt[i].eGv) checkOutput($sformatf("v%0d_gch", i), gch, vt[i].eGch);
    end

    // Burst limit with 100 bytes queued on each channel.
    pulseReset();
    for (int i = 0; i < 100; i++) begin
      q0.push_back(8'(i));
      q1.push_back(8'(8'h80 + i));
    end
    expq.push_back(8'hC0);
    for (int i = 0; i < 64; i++) expq.push_back(8'(i));
    expq.push_back(8'hC1);
    for (int i = 0; i < 64; i++) expq.push_back(8'(8'h80 + i));
    expq.push_back(8'hC0);
    for (int i = 64; i < 100; i++) expq.push_back(8'(i));
    expq.push_back(8'hC1);
    for (int i = 64; i < 100; i++) expq.push_back(8'(8'h80 + i));
    runStream("burst", 600);

    // Granted FIFO drains while the other channel waits.
    pulseReset();
    q0 = '{8'hA1, 8'hA2};
    q1 = '{8'hAB};
    expq = '{8'hC0, 8'hA1, 8'hA2, 8'hC1, 8'hAB};
    runStream("early_switch", 50);

    // Reset in the middle of a channel 1 burst.
    pulseReset();
    for (int i = 0; i < 20; i++) q1.push_back(8'(8'h40 + i));
    OUT_RDREQ = 1'b1;
    n = 0;
    while (got.size() < 11 && n < 100) begin
      applyStimulus(oe, oq, r0, r1, gv, gch);
      n++;
    end
    checkOutput("mid_pre_timeout", (n < 100) ? 32'd0 : 32'd1, 32'd0);
    RST_ASYNC = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(oe, oq, r0, r1, gv, gch);
      checkOutput($sformatf("mid_rst_rd1_%0d", i), r1, 1'b0);
      checkOutput($sformatf("mid_rst_gv_%0d", i), gv, 1'b0);
    end
    checkOutput("mid_rst_remaining", q1.size(), 32'd10);
    RST_ASYNC = 1'b0;
    got.delete();
    expq.delete();
    expq.push_back(8'hC1);
    for (int i = 10; i < 20; i++) expq.push_back(8'(8'h40 + i));
    runStream("mid_resume", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
